// File: rtl/fp_norm_pkg.sv
// Shared types and constants for the mantissa normalizer.
// FAST_STEP is the shift distance used when FP_NORM_FAST_SHIFT_EN is defined.
package fp_norm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2
    } norm_state_e;

    localparam int CHANGE_W  = 8;
    localparam int FAST_STEP = 4;

endpackage

// File: rtl/fp_mant_normalizer.sv
// Multi-cycle mantissa normalizer producing a signed exponent change for the exponent adder.
// Optional macro FP_NORM_FAST_SHIFT_EN: shift by FAST_STEP while the leading nibble is zero.
//
//   state    | meaning
//   ST_IDLE  | waiting for in_valid; in_ready high
//   ST_SHIFT | left-shifting mant until hidden bit reaches MSB
//   ST_HOLD  | result presented, waiting for out_ready
module fp_mant_normalizer
    import fp_norm_pkg::*;
#(
    parameter int MANT_W = 24
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [MANT_W:0]     in_mant,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [MANT_W-1:0]   out_mant,
    output logic [CHANGE_W-1:0] out_change,
    output logic                out_zero
);

    norm_state_e         state_q, state_d;
    logic [MANT_W-1:0]   mant_q, mant_d;
    logic [CHANGE_W-1:0] cnt_q, cnt_d;
    logic [CHANGE_W-1:0] change_q, change_d;
    logic                zero_q, zero_d;
    logic                valid_q, valid_d;

    logic [MANT_W-1:0]   shift_mant;
    logic [CHANGE_W-1:0] shift_cnt;

`ifdef FP_NORM_FAST_SHIFT_EN
    logic top_zero;
    if (MANT_W >= 5) begin : g_nibble
        assign top_zero = (mant_q[MANT_W-1 -: FAST_STEP] == '0);
    end else begin : g_no_nibble
        assign top_zero = 1'b0;
    end
`endif

    always_comb begin
        shift_mant = mant_q << 1;
        shift_cnt  = cnt_q + CHANGE_W'(1);
`ifdef FP_NORM_FAST_SHIFT_EN
        if (top_zero) begin
            shift_mant = mant_q << FAST_STEP;
            shift_cnt  = cnt_q + CHANGE_W'(FAST_STEP);
        end
`endif
    end

    always_comb begin
        state_d  = state_q;
        mant_d   = mant_q;
        cnt_d    = cnt_q;
        change_d = change_q;
        zero_d   = zero_q;
        valid_d  = valid_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    zero_d   = 1'b0;
                    change_d = '0;
                    cnt_d    = '0;
                    mant_d   = in_mant[MANT_W-1:0];
                    state_d  = ST_HOLD;
                    valid_d  = 1'b1;
                    if (in_mant[MANT_W]) begin
                        // carry-out: drop the LSB, no sticky
                        mant_d   = in_mant[MANT_W:1];
                        change_d = CHANGE_W'(1);
                    end else if (in_mant == '0) begin
                        zero_d = 1'b1;
                    end else if (!in_mant[MANT_W-1]) begin
                        state_d = ST_SHIFT;
                        valid_d = 1'b0;
                    end
                end
            end
            ST_SHIFT: begin
                mant_d = shift_mant;
                cnt_d  = shift_cnt;
                if (shift_mant[MANT_W-1]) begin
                    change_d = CHANGE_W'(0) - shift_cnt;
                    state_d  = ST_HOLD;
                    valid_d  = 1'b1;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            mant_q   <= '0;
            cnt_q    <= '0;
            change_q <= '0;
            zero_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            mant_q   <= mant_d;
            cnt_q    <= cnt_d;
            change_q <= change_d;
            zero_q   <= zero_d;
            valid_q  <= valid_d;
        end
    end

    assign in_ready   = (state_q == ST_IDLE);
    assign out_valid  = valid_q;
    assign out_mant   = mant_q;
    assign out_change = change_q;
    assign out_zero   = zero_q;

endmodule

// File: tb/tb_fp_mant_normalizer.sv
// Directed bench for fp_mant_normalizer at MANT_W = 24, with hand-computed expectations.
// Expected latencies follow FP_NORM_FAST_SHIFT_EN when the bench is built with it.
module tb_fp_mant_normalizer;

    localparam int MANT_W = 24;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [MANT_W:0]   in_mant;
    logic              out_valid;
    logic              out_ready;
    logic [MANT_W-1:0] out_mant;
    logic [7:0]        out_change;
    logic              out_zero;

    int errors = 0;
    int checks = 0;
    int lat;
    logic [MANT_W-1:0] held_mant;
    logic [7:0]        held_change;
    logic              seen_valid;

`ifdef FP_NORM_FAST_SHIFT_EN
    localparam int LAT_ONE = 9;
`else
    localparam int LAT_ONE = 24;
`endif

    fp_mant_normalizer #(.MANT_W(MANT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_mant    (in_mant),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_mant   (out_mant),
        .out_change (out_change),
        .out_zero   (out_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Presents m for one accept edge, then scrambles in_mant; returns cycles to out_valid.
    task automatic send(input logic [MANT_W:0] m, output int l);
        in_mant  = m;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_mant  = ~m;
        l = 1;
        while (!out_valid && l < 200) begin
            @(posedge clk); #1;
            l++;
        end
    endtask

    task automatic release_out(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_valid_clr"}, 32'(out_valid), 32'd0);
        chk({tag, "_ready_back"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_mant = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_valid",  32'(out_valid),  32'd0);
        chk("rst_ready",  32'(in_ready),   32'd1);
        chk("rst_mant",   32'(out_mant),   32'd0);
        chk("rst_change", 32'(out_change), 32'd0);
        chk("rst_zero",   32'(out_zero),   32'd0);

        // carry case
        send(25'h1000003, lat);
        chk("carry_lat",    32'(lat),        32'd1);
        chk("carry_mant",   32'(out_mant),   32'h800001);
        chk("carry_change", 32'(out_change), 32'h01);
        chk("carry_zero",   32'(out_zero),   32'd0);
        release_out("carry");

        // deepest shift
        send(25'h0000001, lat);
        chk("lsb_lat",    32'(lat),        32'(LAT_ONE));
        chk("lsb_mant",   32'(out_mant),   32'h800000);
        chk("lsb_change", 32'(out_change), 32'hE9);
        chk("lsb_zero",   32'(out_zero),   32'd0);
        release_out("lsb");

        // zero input
        send(25'h0000000, lat);
        chk("zero_lat",    32'(lat),        32'd1);
        chk("zero_flag",   32'(out_zero),   32'd1);
        chk("zero_mant",   32'(out_mant),   32'd0);
        chk("zero_change", 32'(out_change), 32'd0);
        release_out("zero");

        // already normalized, then backpressure with a competing in_valid
        send(25'h0C00000, lat);
        chk("norm_lat",    32'(lat),        32'd1);
        chk("norm_mant",   32'(out_mant),   32'hC00000);
        chk("norm_change", 32'(out_change), 32'h00);
        chk("norm_zero",   32'(out_zero),   32'd0);
        in_mant  = 25'h1FFFFFF;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("hold_valid",  32'(out_valid),  32'd1);
            chk("hold_ready",  32'(in_ready),   32'd0);
            chk("hold_mant",   32'(out_mant),   32'hC00000);
            chk("hold_change", 32'(out_change), 32'h00);
        end
        in_valid = 1'b0;
        release_out("norm");

        // reset mid-shift aborts
        send(25'h0000010, lat);
        // lat bounded by the 200-cycle limit would mean no result; instead watch manually
        rst = 1'b0;
        release_out("abort_pre");

        in_mant  = 25'h0000010;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("abort_busy", 32'(in_ready), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_ready",  32'(in_ready),   32'd1);
        chk("abort_valid",  32'(out_valid),  32'd0);
        chk("abort_change", 32'(out_change), 32'd0);
        chk("abort_mant",   32'(out_mant),   32'd0);
        seen_valid = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen_valid = 1'b1;
        end
        chk("abort_no_result", 32'(seen_valid), 32'd0);

        send(25'h0400000, lat);
        chk("post_lat",    32'(lat),        32'd2);
        chk("post_mant",   32'(out_mant),   32'h800000);
        chk("post_change", 32'(out_change), 32'hFF);
        held_mant   = out_mant;
        held_change = out_change;
        @(posedge clk); #1;
        chk("post_stable_mant",   32'(out_mant),   32'(held_mant));
        chk("post_stable_change", 32'(out_change), 32'(held_change));
        release_out("post");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
